// File: rtl/mesh_pkg.sv
// mesh_pkg: shared arbiter state encoding, mesh port indices and index-width helper
package mesh_pkg;
    typedef enum logic {IDLE, LOCKED} state_t;
    localparam int PE = 0;
    localparam int N = 1;
    localparam int S = 2;
    localparam int E = 3;
    localparam int W = 4;
    function automatic int idx_w(input int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/mesh_port_arbiter_if.sv
// mesh_port_arbiter_if: requester-side and output-side flit handshakes of one mesh port
interface mesh_port_arbiter_if
    import mesh_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NUM_REQ = 5
);
    localparam int SRC_W = idx_w(NUM_REQ);
    logic [NUM_REQ-1:0] req_valid;
    logic [NUM_REQ-1:0] req_ready;
    logic [NUM_REQ-1:0][WIDTH-1:0] req_data;
    logic out_valid;
    logic out_ready;
    logic [WIDTH-1:0] out_data;
    logic [SRC_W-1:0] out_src;
    modport master (
        output req_valid, req_data, out_ready,
        input req_ready, out_valid, out_data, out_src
    );
    modport slave (
        input req_valid, req_data, out_ready,
        output req_ready, out_valid, out_data, out_src
    );
endinterface

// File: rtl/rr_pick.sv
// rr_pick: first set request at or after ptr, wrapping, as one-hot grant plus index
module rr_pick #(
    parameter int NUM_REQ = 5,
    parameter int IDX_W = 3
) (
    input logic [NUM_REQ-1:0] req,
    input logic [IDX_W-1:0] ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0] idx
);
    int j;
    always_comb begin
        gnt = '0;
        idx = '0;
        j = 0;
        // scan farthest-first so the nearest request at or after ptr is the last write
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = int'(ptr) + k;
            j = j >= NUM_REQ ? j - NUM_REQ : j;
            if (req[j]) begin
                gnt = NUM_REQ'(1) << j;
                idx = IDX_W'(j);
            end
        end
    end
endmodule

// File: rtl/mesh_port_arbiter.sv
// mesh_port_arbiter: packet-locked round-robin arbiter feeding a one-entry output register
module mesh_port_arbiter
    import mesh_pkg::*;
#(
    parameter int WIDTH = 10,
    parameter int NUM_REQ = 5,
    parameter int TAIL_BIT = WIDTH - 1
) (
    input logic clk,
    input logic rst_n,
    mesh_port_arbiter_if.slave bus
);
    localparam int IDX_W = idx_w(NUM_REQ);
    state_t state_q, state_d;
    logic [IDX_W-1:0] lock_q, lock_d, rr_q, rr_d, gnt_idx, out_src_q;
    logic [NUM_REQ-1:0] elig, gnt;
    logic [WIDTH-1:0] sel, out_data_q;
    logic out_valid_q, free, xfer, tail;
    assign free = !out_valid_q || bus.out_ready;
    // while locked only the packet owner may compete, valid or not
    assign elig = state_q == LOCKED ? bus.req_valid & (NUM_REQ'(1) << lock_q) : bus.req_valid;
    rr_pick #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_pick (
        .req(elig),
        .ptr(rr_q),
        .gnt(gnt),
        .idx(gnt_idx)
    );
    assign bus.req_ready = (free && rst_n) ? gnt : '0;
    assign xfer = |bus.req_ready;
    assign sel = bus.req_data[gnt_idx];
    assign tail = sel[TAIL_BIT];
    assign bus.out_valid = out_valid_q;
    assign bus.out_data = out_data_q;
    assign bus.out_src = out_src_q;
    always_comb begin
        state_d = state_q;
        lock_d = lock_q;
        rr_d = rr_q;
        if (xfer) begin
            state_d = tail ? IDLE : LOCKED;
            lock_d = tail ? lock_q : gnt_idx;
            rr_d = tail ? (gnt_idx == IDX_W'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1) : rr_q;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            lock_q <= '0;
            rr_q <= '0;
        end else begin
            state_q <= state_d;
            lock_q <= lock_d;
            rr_q <= rr_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_src_q <= '0;
        end else if (xfer) begin
            out_valid_q <= 1'b1;
            out_data_q <= sel;
            out_src_q <= gnt_idx;
        end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_mesh_port_arbiter.sv
// tb_mesh_port_arbiter: directed mesh-port scenarios plus random traffic against a packet-level model
module tb_mesh_port_arbiter;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mesh_port_arbiter_if #(.WIDTH(10), .NUM_REQ(5)) bus ();
    mesh_port_arbiter #(.WIDTH(10), .NUM_REQ(5), .TAIL_BIT(9)) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int errors = 0;
    int checks = 0;
    int owner;
    int ptr;
    int bs;
    bit bv;
    logic [9:0] bd;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        owner = -1;
        ptr = 0;
        bv = 0;
        bd = '0;
        bs = 0;
    endtask

    // packet-level rule: the owner alone while a packet is open, else first valid from ptr
    function automatic int pick(input logic [4:0] v, input logic ordy);
        if (bv && !ordy) return -1;
        if (owner >= 0) return v[owner] ? owner : -1;
        for (int k = 0; k < 5; k++)
            if (v[(ptr + k) % 5]) return (ptr + k) % 5;
        return -1;
    endfunction

    function automatic logic [9:0] flit(input bit t, input int payload);
        return {t, 9'(payload)};
    endfunction

    task automatic step(input logic [4:0] v, input logic [4:0][9:0] d, input logic ordy, output int g);
        logic [4:0] er;
        @(negedge clk);
        bus.req_valid = v;
        bus.req_data = d;
        bus.out_ready = ordy;
        #1;
        g = pick(v, ordy);
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        chk("req_ready", 32'(bus.req_ready), 32'(er));
        chk("out_valid", 32'(bus.out_valid), 32'(bv));
        if (bv) begin
            chk("out_data", 32'(bus.out_data), 32'(bd));
            chk("out_src", 32'(bus.out_src), 32'(bs));
        end
        @(posedge clk);
        if (g >= 0) begin
            bv = 1;
            bd = d[g];
            bs = g;
            if (d[g][9]) begin
                owner = -1;
                ptr = (g + 1) % 5;
            end else begin
                owner = g;
            end
        end else if (ordy) begin
            bv = 0;
        end
        #1;
    endtask

    initial begin
        logic [4:0][9:0] d;
        logic [4:0] v;
        int g;
        int rem [5];
        d = '0;
        bus.req_valid = '0;
        bus.req_data = '0;
        bus.out_ready = 1'b0;
        model_reset();
        #1;
        chk("rst_out_valid", 32'(bus.out_valid), 0);
        chk("rst_out_data", 32'(bus.out_data), 0);
        chk("rst_out_src", 32'(bus.out_src), 0);
        chk("rst_req_ready", 32'(bus.req_ready), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 10; k++) begin
            step('0, d, 1'b1, g);
            chk("idle_valid", 32'(bus.out_valid), 0);
            chk("idle_ready", 32'(bus.req_ready), 0);
        end

        for (int i = 0; i < 5; i++) d[i] = flit(1, i);
        for (int k = 0; k < 10; k++) begin
            step('1, d, 1'b1, g);
            chk("rr_valid", 32'(bus.out_valid), 1);
            chk("rr_src", 32'(bus.out_src), k % 5);
        end

        d[1] = flit(1, 'h011);
        step(5'b00010, d, 1'b1, g);
        for (int k = 0; k < 4; k++) begin
            d[2] = flit(k == 2, 'h020 + k);
            step(k < 3 ? 5'b00110 : 5'b00010, d, 1'b1, g);
            chk("pkt_src", 32'(bus.out_src), k < 3 ? 2 : 1);
        end

        d[0] = 10'h155;
        step(5'b00001, d, 1'b1, g);
        chk("buf_data", 32'(bus.out_data), 'h155);
        for (int k = 0; k < 4; k++) begin
            step('1, d, 1'b0, g);
            chk("hold_valid", 32'(bus.out_valid), 1);
            chk("hold_data", 32'(bus.out_data), 'h155);
            chk("hold_ready", 32'(bus.req_ready), 0);
        end
        d[0] = 10'h3AA;
        step('1, d, 1'b1, g);
        chk("drain_data", 32'(bus.out_data), 'h3AA);
        chk("drain_src", 32'(bus.out_src), 0);
        step('0, d, 1'b1, g);
        chk("drain_empty", 32'(bus.out_valid), 0);

        d[3] = flit(0, 'h033);
        for (int i = 0; i < 5; i++) if (i != 3) d[i] = flit(1, 'h0A0 + i);
        step(5'b01000, d, 1'b1, g);
        chk("lock_src", 32'(bus.out_src), 3);
        for (int k = 0; k < 2; k++) begin
            step(5'b10111, d, 1'b1, g);
            chk("lock_ready", 32'(bus.req_ready), 0);
            chk("lock_valid", 32'(bus.out_valid), 0);
        end
        d[3] = flit(1, 'h034);
        step('1, d, 1'b1, g);
        chk("resume_src", 32'(bus.out_src), 3);
        chk("resume_data", 32'(bus.out_data), 'h234);

        d[4] = flit(0, 'h044);
        step(5'b10000, d, 1'b1, g);
        chk("pre_rst_src", 32'(bus.out_src), 4);
        @(negedge clk);
        bus.req_valid = '1;
        #2 rst_n = 1'b0;
        #1;
        chk("async_valid", 32'(bus.out_valid), 0);
        chk("async_data", 32'(bus.out_data), 0);
        chk("async_ready", 32'(bus.req_ready), 0);
        model_reset();
        bus.req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        d[0] = flit(1, 1);
        d[4] = flit(1, 2);
        step(5'b10001, d, 1'b1, g);
        chk("post_rst_src", 32'(bus.out_src), 0);

        for (int i = 0; i < 5; i++) begin
            rem[i] = $urandom_range(1, 3);
            d[i] = {rem[i] == 1, 9'($urandom)};
        end
        repeat (3000) begin
            for (int i = 0; i < 5; i++) v[i] = $urandom_range(0, 9) < 7;
            step(v, d, $urandom_range(0, 3) != 0, g);
            if (g >= 0) begin
                rem[g]--;
                if (rem[g] == 0) rem[g] = $urandom_range(1, 3);
                d[g] = {rem[g] == 1, 9'($urandom)};
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mesh_port_arbiter.md
MESH_PORT_ARBITER -- requirements
Module: mesh_port_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 10, flit width in bits.
REQ-002 SHALL have parameter NUM_REQ, default 5, number of requesting input ports: index 0=PE, 1=N, 2=S, 3=E, 4=W.
REQ-003 SHALL have parameter TAIL_BIT, default WIDTH-1, the flit bit that marks the last flit of a packet.
REQ-004 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 SHALL have port req_valid, input, NUM_REQ bits, per-requester flit valid.
REQ-007 SHALL have port req_ready, output, NUM_REQ bits, per-requester flit accept.
REQ-008 SHALL have port req_data, input, NUM_REQ x WIDTH, per-requester flit.
REQ-009 SHALL have port out_valid, output, 1 bit, output flit valid.
REQ-010 SHALL have port out_ready, input, 1 bit, downstream accept.
REQ-011 SHALL have port out_data, output, WIDTH bits, output flit.
REQ-012 SHALL have port out_src, output, $clog2(NUM_REQ) bits, requester index of the flit currently on out_data.

Function
REQ-013 A transfer SHALL occur on a port when valid and ready are both high at a rising edge; valid SHALL NOT depend on ready.
REQ-014 SHALL hold a one-entry output register; the register is "free" when it is empty or being drained this cycle (out_valid && out_ready).
REQ-015 At most one req_ready bit SHALL be high per cycle, and only when the register is free; req_ready SHALL be combinational from state, req_valid and out_ready.
REQ-016 An accepted flit SHALL appear on out_data/out_src with out_valid high the next cycle (latency 1), giving full throughput of one flit per cycle under continuous out_ready.
REQ-017 out_data/out_src SHALL stay stable while out_valid is high and out_ready is low.
REQ-018 FSM states SHALL be IDLE and LOCKED; the FSM SHALL reset to IDLE.
REQ-019 In IDLE, the grant SHALL go round-robin to the first valid requester at or after rr_ptr, wrapping from NUM_REQ-1 to 0.
REQ-020 On an IDLE transfer whose flit has TAIL_BIT=0, the FSM SHALL go to LOCKED with lock_id = the granted index.
REQ-021 On an IDLE transfer whose flit has TAIL_BIT=1 (single-flit packet), the FSM SHALL stay in IDLE.
REQ-022 In LOCKED, only lock_id SHALL be eligible; other requesters SHALL see req_ready=0 even if the locked requester is not valid.
REQ-023 In LOCKED, a transfer with TAIL_BIT=1 SHALL return the FSM to IDLE.
REQ-024 On every transfer with TAIL_BIT=1, rr_ptr SHALL become (granted index + 1) mod NUM_REQ; rr_ptr SHALL NOT change otherwise.
REQ-025 With no valid requester, or the register not free, there SHALL be no grant, and the FSM and rr_ptr SHALL hold.
REQ-026 Drain and refill in the same cycle SHALL be supported: out_valid stays high and out_data takes the new flit.

Reset
REQ-027 rst_n low SHALL asynchronously force out_valid=0, out_data=0, out_src=0, rr_ptr=0, lock_id=0, FSM=IDLE; req_ready SHALL be 0 while rst_n is low.
REQ-028 Reset mid-packet SHALL discard the lock and the buffered flit; after release, arbitration SHALL restart from index 0 in IDLE.

Structure
REQ-029 The FSM state enum and the port-index constants (PE, N, S, E, W) SHALL live in a shared package, mesh_pkg.
REQ-030 The round-robin priority pick SHALL be one sub-module, rr_pick (inputs: request vector and pointer; outputs: one-hot grant and index).

Verification
REQ-031 Reset release, no requests -> out_valid=0 and req_ready=0 for 10 cycles.
REQ-032 All 5 requesters send continuous single-flit packets, out_ready=1 -> out_src sequence 0,1,2,3,4,0..., one flit per cycle.
REQ-033 Req 2 sends a 3-flit packet (tails 0,0,1) while req 1 stays valid -> out_src=2,2,2 contiguous, then 1.
REQ-034 out_ready held low 4 cycles with a flit buffered (data 0x155) -> out_data stays 0x155 and all req_ready=0; the flit drains on the first cycle out_ready=1.
REQ-035 Locked requester 3 deasserts valid for 2 cycles mid-packet -> no other source is granted; the packet resumes.
REQ-036 rst_n pulsed low mid-packet from req 4 -> out_valid=0 at once; after release, req 0 and req 4 both valid -> req 0 is granted first.
